// File: rtl/hdmi_video_out.sv
// 720x480p60 CEA-861 timing generator that scales the 160x144 2-bit Game Boy
// framebuffer 3x and centres it, with DE/HS/VS/frame_start aligned to the pixel data.
module hdmi_video_out #(
  parameter int          H_ACTIVE = 720,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 62,
  parameter int          H_BP     = 60,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 9,
  parameter int          V_SYNC   = 6,
  parameter int          V_BP     = 30,
  parameter int          X_OFF    = 120,
  parameter int          Y_OFF    = 24,
  parameter int          GB_W     = 160,
  parameter int          GB_H     = 144,
  parameter logic [23:0] BORDER   = 24'h000000,
  parameter logic [23:0] SHADE0   = 24'hFFFFFF,
  parameter logic [23:0] SHADE1   = 24'hAAAAAA,
  parameter logic [23:0] SHADE2   = 24'h555555,
  parameter logic [23:0] SHADE3   = 24'h000000
) (
  input  logic        HDMI_TX_CLK,
  input  logic        rst_n,
  output logic [14:0] fb_addr,
  input  logic [1:0]  fb_data,
  output logic        HDMI_TX_DE,
  output logic        HDMI_TX_HS,
  output logic        HDMI_TX_VS,
  output logic [23:0] HDMI_TX_D,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PXW     = $clog2(GB_W);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] X_LO   = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI   = HW'(X_OFF + 3 * GB_W - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] Y_LO   = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_HI   = VW'(Y_OFF + 3 * GB_H - 1);
  localparam logic [14:0]   LB_STEP = 15'(GB_W);

  function automatic logic [23:0] shade_rgb(input logic [1:0] s);
    case (s)
      2'd0:    shade_rgb = SHADE0;
      2'd1:    shade_rgb = SHADE1;
      2'd2:    shade_rgb = SHADE2;
      default: shade_rgb = SHADE3;
    endcase
  endfunction

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [1:0]     hx3_q, hx3_d, vy3_q, vy3_d;
  logic [PXW-1:0] px_q, px_d;
  logic [14:0]    lb_q, lb_d;
  logic [14:0]    fb_addr_q, fb_addr_d;
  logic           h_wrap, in_pic_h, in_pic_v, in_pic, in_pic_nx;
  logic           de0, hs0, vs0, fs0;

  logic           in_pic_p1, de_p1, hs_p1, vs_p1, fs_p1;
  logic           de_p2, hs_p2, vs_p2, fs_p2;
  logic [23:0]    d_p2, d_d;

  // Stage 0: raster counters, picture window and framebuffer address for the
  // position the counters will hold next, so fb_addr always matches h_q/v_q.
  always_comb begin
    h_wrap    = (h_q == H_LAST);
    h_d       = h_wrap ? '0 : h_q + 1'b1;
    v_d       = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;

    in_pic_h  = (h_q >= X_LO) && (h_q <= X_HI);
    in_pic_v  = (v_q >= Y_LO) && (v_q <= Y_HI);
    in_pic    = in_pic_h && in_pic_v;
    in_pic_nx = (h_d >= X_LO) && (h_d <= X_HI) && (v_d >= Y_LO) && (v_d <= Y_HI);

    de0 = (h_q < H_ACT) && (v_q < V_ACT);
    hs0 = !((h_q >= HS_LO) && (h_q <= HS_HI));
    vs0 = !((v_q >= VS_LO) && (v_q <= VS_HI));
    fs0 = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    hx3_d = hx3_q;
    px_d  = px_q;
    vy3_d = vy3_q;
    lb_d  = lb_q;
    // The last picture column clears px so nothing carries past the picture.
    if (in_pic) begin
      if (h_q == X_HI) begin
        hx3_d = '0;
        px_d  = '0;
      end else if (hx3_q == 2'd2) begin
        hx3_d = '0;
        px_d  = px_q + 1'b1;
      end else begin
        hx3_d = hx3_q + 1'b1;
      end
    end
    if (h_wrap) begin
      hx3_d = '0;
      px_d  = '0;
      if ((v_q == V_LAST) || (v_q == Y_HI)) begin
        vy3_d = '0;
        lb_d  = '0;
      end else if (in_pic_v) begin
        if (vy3_q == 2'd2) begin
          vy3_d = '0;
          lb_d  = lb_q + LB_STEP;
        end else begin
          vy3_d = vy3_q + 1'b1;
        end
      end
    end
    fb_addr_d = in_pic_nx ? lb_d + 15'(px_d) : fb_addr_q;
  end

  always_ff @(posedge HDMI_TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      hx3_q     <= '0;
      px_q      <= '0;
      vy3_q     <= '0;
      lb_q      <= '0;
      fb_addr_q <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      hx3_q     <= hx3_d;
      px_q      <= px_d;
      vy3_q     <= vy3_d;
      lb_q      <= lb_d;
      fb_addr_q <= fb_addr_d;
    end
  end

  // Stage 1: framebuffer data returns; timing flags wait alongside it.
  always_ff @(posedge HDMI_TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      in_pic_p1 <= 1'b0;
      de_p1     <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      fs_p1     <= 1'b0;
    end else begin
      in_pic_p1 <= in_pic;
      de_p1     <= de0;
      hs_p1     <= hs0;
      vs_p1     <= vs0;
      fs_p1     <= fs0 && de0;
    end
  end

  always_comb begin
    d_d = '0;
    if (de_p1) d_d = in_pic_p1 ? shade_rgb(fb_data) : BORDER;
  end

  // Stage 2: registered pins.
  always_ff @(posedge HDMI_TX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      de_p2 <= 1'b0;
      hs_p2 <= 1'b1;
      vs_p2 <= 1'b1;
      fs_p2 <= 1'b0;
      d_p2  <= '0;
    end else begin
      de_p2 <= de_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
      fs_p2 <= fs_p1;
      d_p2  <= d_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign HDMI_TX_DE  = de_p2;
  assign HDMI_TX_HS  = hs_p2;
  assign HDMI_TX_VS  = vs_p2;
  assign HDMI_TX_D   = d_p2;
  assign frame_start = fs_p2;

endmodule

// File: tb/tb_hdmi_video_out.sv
// Bench for hdmi_video_out: a full-size instance over the top of a frame and a
// shrunken-raster instance over whole frames, both checked against a raster model.
module tb_hdmi_video_out;

  // index 0 = full 720x480 instance, index 1 = shrunken instance
  localparam int HT [2] = '{858, 56};
  localparam int VT [2] = '{525, 38};
  localparam int HA [2] = '{720, 40};
  localparam int VA [2] = '{480, 30};
  localparam int HSL[2] = '{736, 44};
  localparam int HSW[2] = '{62, 6};
  localparam int VSL[2] = '{489, 32};
  localparam int VSW[2] = '{6, 3};
  localparam int XO [2] = '{120, 5};
  localparam int YO [2] = '{24, 3};
  localparam int GW [2] = '{160, 8};
  localparam int GH [2] = '{144, 6};
  localparam logic [23:0] BORD[2] = '{24'h000000, 24'h0000FF};

  logic        clk = 1'b0;
  logic        rst_n_l = 1'b0, rst_n_s = 1'b0;
  logic [14:0] addr_l, addr_s;
  logic [1:0]  fbd_l, fbd_s;
  logic        de_l, hs_l, vs_l, fs_l, de_s, hs_s, vs_s, fs_s;
  logic [23:0] d_l, d_s;
  logic [1:0]  mem_l[0:32767];
  logic [1:0]  mem_s[0:63];
  int          kl, ks;
  logic [14:0] ea_l, ea_s;
  int          n_tests = 0, n_fail = 0;

  int   t_cyc[2], t_hsf[2], t_vsf[2], t_der[2], t_del[2];
  logic t_fs[2], t_hs[2], t_vs[2], t_de[2];
  logic [14:0] amax_s;
  logic        aseen_s;

  always #5 clk = ~clk;

  hdmi_video_out u_full (
    .HDMI_TX_CLK(clk), .rst_n(rst_n_l), .fb_addr(addr_l), .fb_data(fbd_l),
    .HDMI_TX_DE(de_l), .HDMI_TX_HS(hs_l), .HDMI_TX_VS(vs_l), .HDMI_TX_D(d_l),
    .frame_start(fs_l)
  );

  hdmi_video_out #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .X_OFF(5), .Y_OFF(3), .GB_W(8), .GB_H(6), .BORDER(24'h0000FF)
  ) u_small (
    .HDMI_TX_CLK(clk), .rst_n(rst_n_s), .fb_addr(addr_s), .fb_data(fbd_s),
    .HDMI_TX_DE(de_s), .HDMI_TX_HS(hs_s), .HDMI_TX_VS(vs_s), .HDMI_TX_D(d_s),
    .frame_start(fs_s)
  );

  // framebuffer RAMs: data one clock after the address
  always @(posedge clk) fbd_l <= mem_l[addr_l];
  always @(posedge clk) fbd_s <= mem_s[addr_s[5:0]];

  // clocks since reset release = raster position held by the counters
  always @(posedge clk or negedge rst_n_l) if (!rst_n_l) kl <= 0; else kl <= kl + 1;
  always @(posedge clk or negedge rst_n_s) if (!rst_n_s) ks <= 0; else ks <= ks + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] shade(input logic [1:0] s);
    case (s)
      2'd0:    return 24'hFFFFFF;
      2'd1:    return 24'hAAAAAA;
      2'd2:    return 24'h555555;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit pic_pos(input int i, input int p, output int a);
    int h, v;
    h = p % HT[i];
    v = (p / HT[i]) % VT[i];
    a = 0;
    if (h >= XO[i] && h < XO[i] + 3 * GW[i] && v >= YO[i] && v < YO[i] + 3 * GH[i]) begin
      a = ((v - YO[i]) / 3) * GW[i] + (h - XO[i]) / 3;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // {frame_start, DE, HS, VS, D, fb_addr} expected k clocks after release
  function automatic logic [42:0] model(input int i, input int k, input logic [14:0] ea);
    int p, h, v, a;
    logic de, hs, vs, fs;
    logic [23:0] d;
    if (k < 2) return {1'b0, 1'b0, 1'b1, 1'b1, 24'h0, ea};
    p  = k - 2;
    h  = p % HT[i];
    v  = (p / HT[i]) % VT[i];
    de = (h < HA[i]) && (v < VA[i]);
    hs = !(h >= HSL[i] && h < HSL[i] + HSW[i]);
    vs = !(v >= VSL[i] && v < VSL[i] + VSW[i]);
    fs = (h == 0) && (v == 0);
    d  = 24'h0;
    if (de) begin
      if (pic_pos(i, p, a)) d = shade((i == 1) ? mem_s[a] : mem_l[a]);
      else d = BORD[i];
    end
    return {fs, de, hs, vs, d, ea};
  endfunction

  task automatic track(input int i, input logic rn, input logic de, input logic hs,
                       input logic vs, input logic fs);
    if (!rn) begin
      t_cyc[i] = 0; t_hsf[i] = -1; t_vsf[i] = -1; t_der[i] = 0; t_del[i] = 0;
      t_fs[i] = 1'b0; t_hs[i] = 1'b1; t_vs[i] = 1'b1; t_de[i] = 1'b0;
      return;
    end
    t_cyc[i]++;
    if (t_hs[i] && !hs) begin
      if (t_hsf[i] >= 0) check("hs_period", 64'(t_cyc[i] - t_hsf[i]), 64'(HT[i]));
      t_hsf[i] = t_cyc[i];
    end
    if (!t_hs[i] && hs && t_hsf[i] >= 0) check("hs_width", 64'(t_cyc[i] - t_hsf[i]), 64'(HSW[i]));
    if (t_vs[i] && !vs) begin
      if (t_vsf[i] >= 0) check("vs_period", 64'(t_cyc[i] - t_vsf[i]), 64'(HT[i] * VT[i]));
      t_vsf[i] = t_cyc[i];
    end
    if (!t_vs[i] && vs && t_vsf[i] >= 0) check("vs_width", 64'(t_cyc[i] - t_vsf[i]), 64'(VSW[i] * HT[i]));
    if (de) t_der[i]++;
    if (t_de[i] && !de) begin
      check("de_run", 64'(t_der[i]), 64'(HA[i]));
      t_der[i] = 0;
      t_del[i]++;
    end
    if (fs) begin
      if (t_fs[i]) check("de_lines", 64'(t_del[i]), 64'(VA[i]));
      t_fs[i]  = 1'b1;
      t_del[i] = 0;
    end
    t_hs[i] = hs; t_vs[i] = vs; t_de[i] = de;
  endtask

  // spot pixels on the full instance: (h, v, expected D), all with DE=1
  int          sl_h[8] = '{120, 123, 126, 129, 122, 119, 600, 120};
  int          sl_v[8] = '{24, 24, 24, 24, 26, 24, 24, 23};
  logic [23:0] sl_d[8] = '{24'hFFFFFF, 24'hAAAAAA, 24'h555555, 24'h000000,
                           24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};
  int          al_v[3] = '{24, 27, 30};
  logic [14:0] al_a[3] = '{15'd0, 15'd160, 15'd320};
  // spot pixels on the shrunken instance: border all round, corner reads the last address
  int          ss_h[5] = '{4, 29, 5, 5, 28};
  int          ss_v[5] = '{3, 3, 2, 21, 20};
  logic [23:0] ss_d[5] = '{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h000000};

  always @(negedge clk) begin : chk_full
    logic [42:0] e;
    int a;
    if (!rst_n_l) ea_l = '0;
    else if (pic_pos(0, kl, a)) ea_l = 15'(a);
    e = rst_n_l ? model(0, kl, ea_l) : {1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 15'h0};
    check("out_full", 64'({fs_l, de_l, hs_l, vs_l, d_l, addr_l}), 64'(e));
    track(0, rst_n_l, de_l, hs_l, vs_l, fs_l);
    if (rst_n_l) begin
      for (int j = 0; j < 8; j++)
        if (kl == sl_v[j] * HT[0] + sl_h[j] + 2) check("pix_full", 64'({de_l, d_l}), 64'({1'b1, sl_d[j]}));
      for (int j = 0; j < 3; j++)
        if (kl == al_v[j] * HT[0] + XO[0]) check("addr_line", 64'(addr_l), 64'(al_a[j]));
    end
  end

  always @(negedge clk) begin : chk_small
    logic [42:0] e;
    int a;
    if (!rst_n_s) ea_s = '0;
    else if (pic_pos(1, ks, a)) ea_s = 15'(a);
    e = rst_n_s ? model(1, ks, ea_s) : {1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 15'h0};
    check("out_small", 64'({fs_s, de_s, hs_s, vs_s, d_s, addr_s}), 64'(e));
    track(1, rst_n_s, de_s, hs_s, vs_s, fs_s);
    if (!rst_n_s) begin
      aseen_s = 1'b0;
      amax_s  = '0;
    end else begin
      for (int j = 0; j < 5; j++)
        if ((ks - 2) % (HT[1] * VT[1]) == ss_v[j] * HT[1] + ss_h[j] && ks >= 2)
          check("pix_small", 64'({de_s, d_s}), 64'({1'b1, ss_d[j]}));
      if (fs_s) begin
        if (aseen_s) check("addr_max", 64'(amax_s), 64'(GW[1] * GH[1] - 1));
        aseen_s = 1'b1;
        amax_s  = '0;
      end
      if (addr_s > amax_s) amax_s = addr_s;
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem_l[i] = 2'(i);
    for (int i = 0; i < 64; i++) mem_s[i] = 2'($urandom_range(0, 3));
    mem_s[47] = 2'd3;
    repeat (3) @(negedge clk);
    #1;
    rst_n_l = 1'b1;
    rst_n_s = 1'b1;
    fork
      begin
        repeat (31 * 858 + 400) @(negedge clk);
        #1 rst_n_l = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n_l = 1'b1;
        repeat (3000) @(negedge clk);
      end
      begin
        repeat (2 * 2128 + $urandom_range(0, 2127)) @(negedge clk);
        #1 rst_n_s = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n_s = 1'b1;
        repeat (3 * 2128 + 100) @(negedge clk);
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
